// File: rtl/conv1_pkg.sv
// Shared constants, address widths and FSM state type for the conv1 layer sequencer.
package conv1_pkg;

    localparam int unsigned IMG_W  = 28;
    localparam int unsigned K      = 5;
    localparam int unsigned OUT_W  = IMG_W - K + 1;
    localparam int unsigned N_TAPS = K * K;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TAP_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KCLR,
        ST_LOAD_K,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_FIN
    } conv1_state_t;

endpackage

// File: rtl/conv1_win_addr.sv
// Window/tap counters for conv1: registered image-RAM and output-RAM addresses,
// maintained incrementally so no multiplier is needed.
module conv1_win_addr
    import conv1_pkg::*;
#(
    parameter int unsigned IMG_W = conv1_pkg::IMG_W,
    parameter int unsigned K     = conv1_pkg::K
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              step,
    input  logic              next_win,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [TAP_W-1:0]  tap,
    output logic              last_tap,
    output logic              last_win
);

    localparam int unsigned WIN_N = IMG_W - K + 1;
    localparam int unsigned CNT_W = $clog2(WIN_N);
    localparam int unsigned KC_W  = $clog2(K);
    // Jump from the last tap of one kernel row to the first tap of the next.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - K + 1);
    // Jump from window (r, WIN_N-1) to window (r+1, 0).
    localparam logic [ADDR_W-1:0] COL_WRAP = ADDR_W'(IMG_W - WIN_N + 1);

    logic [CNT_W-1:0]  row, col;
    logic [KC_W-1:0]   i, j;
    logic [ADDR_W-1:0] base;

    assign last_tap = (i == KC_W'(K - 1)) && (j == KC_W'(K - 1));
    assign last_win = (row == CNT_W'(WIN_N - 1)) && (col == CNT_W'(WIN_N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row      <= '0;
            col      <= '0;
            i        <= '0;
            j        <= '0;
            tap      <= '0;
            base     <= '0;
            img_addr <= '0;
            out_addr <= '0;
        end else if (clr) begin
            row      <= '0;
            col      <= '0;
            i        <= '0;
            j        <= '0;
            tap      <= '0;
            base     <= '0;
            img_addr <= '0;
            out_addr <= '0;
        end else if (next_win) begin
            i   <= '0;
            j   <= '0;
            tap <= '0;
            if (last_win) begin
                row      <= '0;
                col      <= '0;
                base     <= '0;
                img_addr <= '0;
                out_addr <= '0;
            end else begin
                out_addr <= out_addr + ADDR_W'(1);
                if (col == CNT_W'(WIN_N - 1)) begin
                    col      <= '0;
                    row      <= row + CNT_W'(1);
                    base     <= base + COL_WRAP;
                    img_addr <= base + COL_WRAP;
                end else begin
                    col      <= col + CNT_W'(1);
                    base     <= base + ADDR_W'(1);
                    img_addr <= base + ADDR_W'(1);
                end
            end
        end else if (step) begin
            if (last_tap) begin
                i        <= '0;
                j        <= '0;
                tap      <= '0;
                img_addr <= base;
            end else begin
                tap <= tap + TAP_W'(1);
                if (j == KC_W'(K - 1)) begin
                    j        <= '0;
                    i        <= i + KC_W'(1);
                    img_addr <= img_addr + ROW_STEP;
                end else begin
                    j        <= j + KC_W'(1);
                    img_addr <= img_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv1_sched.sv
// Conv1 layer sequencer: loads kernel taps, walks all output windows, aligns MAC strobes.
// Optional abort input is enabled by defining CONV1_SCHED_ABORT_EN.
module conv1_sched
    import conv1_pkg::*;
#(
    parameter int unsigned IMG_W   = conv1_pkg::IMG_W,
    parameter int unsigned K       = conv1_pkg::K,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              k_clr,
    output logic              k_en,
    input  logic              k_done,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    output logic              mac_clr,
    output logic              mac_valid,
    output logic [TAP_W-1:0]  tap,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr
`ifdef CONV1_SCHED_ABORT_EN
    ,
    input  logic              abort
`endif
);

    conv1_state_t      state, state_nxt;
    logic [1:0]        drain_cnt, drain_nxt;
    logic              step, next_win, win_clr;
    logic              last_tap, last_win;
    logic [TAP_W-1:0]  win_tap;
    logic              abort_req;

    logic [MEM_LAT-1:0] pipe_v, pipe_c;
    logic [TAP_W-1:0]   pipe_t [MEM_LAT];

`ifdef CONV1_SCHED_ABORT_EN
    assign abort_req = abort && (state != ST_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    conv1_win_addr #(
        .IMG_W (IMG_W),
        .K     (K)
    ) u_win_addr (
        .clk      (clk),
        .reset    (reset),
        .clr      (win_clr),
        .step     (step),
        .next_win (next_win),
        .img_addr (img_addr),
        .out_addr (out_addr),
        .tap      (win_tap),
        .last_tap (last_tap),
        .last_win (last_win)
    );

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        step      = 1'b0;
        next_win  = 1'b0;
        win_clr   = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_KCLR;
            ST_KCLR: begin
                win_clr   = 1'b1;
                state_nxt = ST_LOAD_K;
            end
            ST_LOAD_K: if (k_done) state_nxt = ST_READ;
            // The counters always hold the tap currently on img_addr, so step here.
            ST_READ: begin
                step = 1'b1;
                if (last_tap) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'(MEM_LAT - 1)) state_nxt = ST_WRITE;
                else                              drain_nxt = drain_cnt + 2'd1;
            end
            ST_WRITE: begin
                next_win  = 1'b1;
                state_nxt = last_win ? ST_FIN : ST_READ;
            end
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort_req) begin
            state_nxt = ST_IDLE;
            drain_nxt = '0;
            step      = 1'b0;
            next_win  = 1'b0;
            win_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Strobes decoded from the next state so every output comes straight off a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            k_clr  <= 1'b0;
            k_en   <= 1'b0;
            img_rd <= 1'b0;
            out_we <= 1'b0;
        end else begin
            busy   <= (state_nxt != ST_IDLE);
            done   <= (state_nxt == ST_FIN);
            k_clr  <= (state_nxt == ST_KCLR);
            k_en   <= (state_nxt == ST_LOAD_K);
            img_rd <= (state_nxt == ST_READ);
            out_we <= (state_nxt == ST_WRITE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_v <= '0;
            pipe_c <= '0;
            for (int unsigned s = 0; s < MEM_LAT; s++) pipe_t[s] <= '0;
        end else if (abort_req) begin
            pipe_v <= '0;
            pipe_c <= '0;
            for (int unsigned s = 0; s < MEM_LAT; s++) pipe_t[s] <= '0;
        end else begin
            pipe_v[0] <= img_rd;
            pipe_c[0] <= img_rd && (win_tap == '0);
            pipe_t[0] <= img_rd ? win_tap : '0;
            for (int unsigned s = 1; s < MEM_LAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_c[s] <= pipe_c[s-1];
                pipe_t[s] <= pipe_t[s-1];
            end
        end
    end

    assign mac_valid = pipe_v[MEM_LAT-1];
    assign mac_clr   = pipe_c[MEM_LAT-1];
    assign tap       = pipe_t[MEM_LAT-1];

endmodule

// File: tb/tb_conv1_sched.sv
// Directed self-checking bench for conv1_sched (MEM_LAT=2); covers abort when
// CONV1_SCHED_ABORT_EN is defined.
module tb_conv1_sched;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy, done, k_clr, k_en, k_done;
    logic       img_rd, mac_clr, mac_valid, out_we;
    logic [9:0] img_addr, out_addr;
    logic [4:0] tap;
`ifdef CONV1_SCHED_ABORT_EN
    logic       abort;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    conv1_sched #(
        .IMG_W   (28),
        .K       (5),
        .MEM_LAT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .k_clr     (k_clr),
        .k_en      (k_en),
        .k_done    (k_done),
        .img_rd    (img_rd),
        .img_addr  (img_addr),
        .mac_clr   (mac_clr),
        .mac_valid (mac_valid),
        .tap       (tap),
        .out_we    (out_we),
        .out_addr  (out_addr)
`ifdef CONV1_SCHED_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation state, sampled on the falling edge.
    int unsigned cyc, rd_count, we_idx;
    int unsigned n_we, n_mv, n_mc, n_kclr, n_done;
    int unsigned addr_err, align_err, we_err;
    int unsigned ken_run, ken_len, ken_first_cyc, kclr_cyc;
    int unsigned first_rd_cyc, done_cyc, last_we_cyc, last_mv24_cyc;
    int unsigned last_rd_addr;
    logic [9:0]  first_addr [25];
    logic        hv [3];
    logic [4:0]  ht [3];

    initial begin
        cyc = 0; rd_count = 0; we_idx = 0; ken_run = 0; ken_len = 0;
        k_done = 1'b0;
        for (int s = 0; s < 3; s++) begin hv[s] = 1'b0; ht[s] = '0; end
    end

    always @(negedge clk) begin
        int unsigned idx, win, exp_addr;
        cyc++;
        // Weight reader model: finishes after k_en has been high for 25 cycles.
        if (k_en) begin
            if (ken_run == 0) ken_first_cyc = cyc;
            ken_run++;
        end else begin
            if (ken_run != 0) ken_len = ken_run;
            ken_run = 0;
        end
        k_done = k_en && (ken_run >= 25);
        if (!reset) begin
            for (int s = 0; s < 3; s++) begin hv[s] = 1'b0; ht[s] = '0; end
        end else begin
            if (k_clr) begin
                n_kclr++;
                kclr_cyc = cyc;
                rd_count = 0;
                we_idx   = 0;
            end
            idx = rd_count % 25;
            win = rd_count / 25;
            if (img_rd) begin
                exp_addr = (win / 24 + idx / 5) * 28 + (win % 24) + (idx % 5);
                if (img_addr !== 10'(exp_addr)) addr_err++;
                if (rd_count < 25) first_addr[rd_count] = img_addr;
                if (rd_count == 0) first_rd_cyc = cyc;
                last_rd_addr = img_addr;
                rd_count++;
            end
            hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = img_rd;
            ht[2] = ht[1]; ht[1] = ht[0]; ht[0] = 5'(idx);
            if (mac_valid !== hv[2]) align_err++;
            if (hv[2] && (tap !== ht[2])) align_err++;
            if (mac_clr !== (hv[2] && (ht[2] == 5'd0))) align_err++;
            if (mac_valid) n_mv++;
            if (mac_clr) n_mc++;
            if (out_we) begin
                if (out_addr !== 10'(we_idx)) we_err++;
                if (last_mv24_cyc != cyc - 1) we_err++;
                we_idx++;
                n_we++;
                last_we_cyc = cyc;
            end
            if (mac_valid && (tap == 5'd24)) last_mv24_cyc = cyc;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (last_we_cyc != cyc - 1) we_err++;
            end
        end
    end

    task automatic clear_stats();
        @(posedge clk); #2;
        n_we = 0; n_mv = 0; n_mc = 0; n_kclr = 0; n_done = 0;
        addr_err = 0; align_err = 0; we_err = 0; ken_len = 0;
        first_rd_cyc = 0; done_cyc = 0; last_rd_addr = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
`ifdef CONV1_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)      begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (k_clr !== 1'b0)     begin miscompares++; $display("FAIL reset_k_clr: got %b want 0", k_clr); end
        vectors++; if (k_en !== 1'b0)      begin miscompares++; $display("FAIL reset_k_en: got %b want 0", k_en); end
        vectors++; if (img_rd !== 1'b0)    begin miscompares++; $display("FAIL reset_img_rd: got %b want 0", img_rd); end
        vectors++; if (img_addr !== 10'd0) begin miscompares++; $display("FAIL reset_img_addr: got %0d want 0", img_addr); end
        vectors++; if (mac_clr !== 1'b0)   begin miscompares++; $display("FAIL reset_mac_clr: got %b want 0", mac_clr); end
        vectors++; if (mac_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mac_valid: got %b want 0", mac_valid); end
        vectors++; if (tap !== 5'd0)       begin miscompares++; $display("FAIL reset_tap: got %0d want 0", tap); end
        vectors++; if (out_we !== 1'b0)    begin miscompares++; $display("FAIL reset_out_we: got %b want 0", out_we); end
        vectors++; if (out_addr !== 10'd0) begin miscompares++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_window();
        int unsigned exp;
        clear_stats();
        pulse_start();
        for (int n = 0; n < 200 && rd_count < 25; n++) @(negedge clk);
        vectors++;
        if (rd_count < 25) begin miscompares++; $display("FAIL first_window_timeout: got %0d reads want 25", rd_count); end
        vectors++; if (n_kclr !== 1)  begin miscompares++; $display("FAIL k_clr_width: got %0d cycles want 1", n_kclr); end
        vectors++; if (ken_len !== 25) begin miscompares++; $display("FAIL k_en_length: got %0d want 25", ken_len); end
        vectors++;
        if (ken_first_cyc !== kclr_cyc + 1) begin
            miscompares++; $display("FAIL k_en_after_k_clr: got %0d want %0d", ken_first_cyc, kclr_cyc + 1);
        end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_in_pass: got %b want 1", busy); end
        for (int t = 0; t < 25; t++) begin
            exp = (t / 5) * 28 + (t % 5);
            vectors++;
            if (first_addr[t] !== 10'(exp)) begin
                miscompares++; $display("FAIL first_addr[%0d]: got %0d want %0d", t, first_addr[t], exp);
            end
        end
    endtask

    task automatic test_full_pass();
        for (int n = 0; n < 17000 && n_done == 0; n++) @(negedge clk);
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL pass_done_count: got %0d want 1", n_done); end
        vectors++; if (n_we !== 576) begin miscompares++; $display("FAIL pass_out_we_count: got %0d want 576", n_we); end
        vectors++; if (we_err !== 0) begin miscompares++; $display("FAIL pass_out_order: got %0d errors want 0", we_err); end
        vectors++; if (n_mv !== 14400) begin miscompares++; $display("FAIL pass_mac_valid_count: got %0d want 14400", n_mv); end
        vectors++; if (n_mc !== 576) begin miscompares++; $display("FAIL pass_mac_clr_count: got %0d want 576", n_mc); end
        vectors++; if (align_err !== 0) begin miscompares++; $display("FAIL pass_alignment: got %0d errors want 0", align_err); end
        vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL pass_img_addr: got %0d errors want 0", addr_err); end
        vectors++; if (last_rd_addr !== 783) begin miscompares++; $display("FAIL pass_last_addr: got %0d want 783", last_rd_addr); end
        vectors++;
        if (done_cyc - first_rd_cyc !== 16128) begin
            miscompares++; $display("FAIL pass_latency: got %0d want 16128", done_cyc - first_rd_cyc);
        end
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pass_idle_busy: got %b want 0", busy); end
        vectors++; if (n_kclr !== 1) begin miscompares++; $display("FAIL pass_k_clr_count: got %0d want 1", n_kclr); end
    endtask

    task automatic test_start_during_read();
        clear_stats();
        pulse_start();
        for (int n = 0; n < 200 && rd_count < 10; n++) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 4000 && rd_count < 2505; n++) @(negedge clk);
        vectors++; if (rd_count < 2505) begin miscompares++; $display("FAIL window100_timeout: got %0d reads want 2505", rd_count); end
        vectors++; if (n_kclr !== 1) begin miscompares++; $display("FAIL restart_ignored: got %0d k_clr want 1", n_kclr); end
        vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL restart_addr: got %0d errors want 0", addr_err); end
        vectors++; if (align_err !== 0) begin miscompares++; $display("FAIL restart_align: got %0d errors want 0", align_err); end
        vectors++; if (n_we !== 100) begin miscompares++; $display("FAIL restart_we_count: got %0d want 100", n_we); end
    endtask

    task automatic test_reset_mid_pass();
        reset = 1'b0;
        #1;
        vectors++;
        if ({busy, done, k_clr, k_en, img_rd, mac_clr, mac_valid, out_we} !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_strobes: got %b want 00000000", {busy, done, k_clr, k_en, img_rd, mac_clr, mac_valid, out_we});
        end
        vectors++; if (img_addr !== 10'd0) begin miscompares++; $display("FAIL midreset_img_addr: got %0d want 0", img_addr); end
        vectors++; if (out_addr !== 10'd0) begin miscompares++; $display("FAIL midreset_out_addr: got %0d want 0", out_addr); end
        vectors++; if (tap !== 5'd0) begin miscompares++; $display("FAIL midreset_tap: got %0d want 0", tap); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL midreset_done: got %0d want 0", n_done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
    endtask

    task automatic test_clean_pass();
        clear_stats();
        pulse_start();
        for (int n = 0; n < 17500 && n_done == 0; n++) @(negedge clk);
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL clean_done: got %0d want 1", n_done); end
        vectors++; if (n_we !== 576) begin miscompares++; $display("FAIL clean_we_count: got %0d want 576", n_we); end
        vectors++; if (we_err !== 0) begin miscompares++; $display("FAIL clean_out_order: got %0d errors want 0", we_err); end
        vectors++; if (addr_err !== 0) begin miscompares++; $display("FAIL clean_img_addr: got %0d errors want 0", addr_err); end
        vectors++; if (align_err !== 0) begin miscompares++; $display("FAIL clean_align: got %0d errors want 0", align_err); end
        vectors++; if (n_kclr !== 1) begin miscompares++; $display("FAIL clean_k_clr: got %0d want 1", n_kclr); end
        repeat (3) @(negedge clk);
    endtask

`ifdef CONV1_SCHED_ABORT_EN
    task automatic test_abort();
        clear_stats();
        pulse_start();
        // Stop at the first DRAIN cycle of window 3.
        for (int n = 0; n < 500 && !(rd_count == 100 && !img_rd); n++) @(negedge clk);
        vectors++; if (rd_count !== 100) begin miscompares++; $display("FAIL abort_reach_drain: got %0d reads want 100", rd_count); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++;
        if ({k_en, img_rd, out_we, mac_valid} !== 4'b0000) begin
            miscompares++; $display("FAIL abort_strobes: got %b want 0000", {k_en, img_rd, out_we, mac_valid});
        end
        repeat (10) @(negedge clk);
        vectors++; if (n_we !== 3) begin miscompares++; $display("FAIL abort_we_count: got %0d want 3", n_we); end
        vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL abort_done: got %0d want 0", n_done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got %b want 0", busy); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        test_reset();
        test_first_window();
        test_full_pass();
        test_start_during_read();
        test_reset_mid_pass();
        test_clean_pass();
`ifdef CONV1_SCHED_ABORT_EN
        test_abort();
        test_clean_pass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
